// File: rtl/empaq_pkg.sv
// Shared constants and state type for the 2-bit symbol packer.
// Optional EMPAQ_PARITY_EN adds a registered parity bit beside the packed word.
package empaq_pkg;

  localparam int unsigned SYM_W_DEF   = 2;
  localparam int unsigned N_SLOTS_DEF = 4;

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    LLENANDO  = 2'd1,
    BLOQUEADO = 2'd2
  } estado_e;

endpackage

// File: rtl/empaquetador_2a8_if.sv
// Symbol-in / word-out handshake bundle for empaquetador_2a8.
// parity_out exists only when EMPAQ_PARITY_EN is defined.
interface empaquetador_2a8_if #(
  parameter int unsigned SYM_W = 2,
  parameter int unsigned OUT_W = 8
);

  logic             valid_in;
  logic [SYM_W-1:0] data_in;
  logic             ready_out;
  logic             valid_out;
  logic [OUT_W-1:0] data_out;
  logic             ready_in;
`ifdef EMPAQ_PARITY_EN
  logic             parity_out;
`endif

  modport slave (
    input  valid_in,
    input  data_in,
    input  ready_in,
    output ready_out,
    output valid_out,
    output data_out
`ifdef EMPAQ_PARITY_EN
    , output parity_out
`endif
  );

  modport master (
    output valid_in,
    output data_in,
    output ready_in,
    input  ready_out,
    input  valid_out,
    input  data_out
`ifdef EMPAQ_PARITY_EN
    , input parity_out
`endif
  );

endinterface

// File: rtl/empaq_reg_salida.sv
// Output holding register with valid/ready; a load always wins over a transfer.
// EMPAQ_PARITY_EN adds a parity bit registered with the word.
module empaq_reg_salida #(
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,  // synchronous
  input  logic             load_i,
  input  logic [OUT_W-1:0] word_i,
  input  logic             ready_i,
`ifdef EMPAQ_PARITY_EN
  output logic             parity_o,
`endif
  output logic             valid_o,
  output logic [OUT_W-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
`ifdef EMPAQ_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
`ifdef EMPAQ_PARITY_EN
    parity_d = parity_q;
`endif
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = word_i;
`ifdef EMPAQ_PARITY_EN
      parity_d = ^word_i;
`endif
    end else if (valid_q && ready_i) begin
      // data is left as-is after a transfer; only valid drops
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef EMPAQ_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
`ifdef EMPAQ_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
`ifdef EMPAQ_PARITY_EN
  assign parity_o = parity_q;
`endif

endmodule

// File: rtl/empaquetador_2a8.sv
// Packs N_SLOTS consecutive SYM_W-bit symbols into one word, slot 0 in the LSBs.
// Define EMPAQ_PARITY_EN to add a registered parity_out on the word.
module empaquetador_2a8
  import empaq_pkg::*;
#(
  parameter int unsigned SYM_W   = SYM_W_DEF,
  parameter int unsigned N_SLOTS = N_SLOTS_DEF,  // legal range 2..8
  localparam int unsigned OUT_W  = SYM_W * N_SLOTS
) (
  input logic               clk,
  input logic               reset_L,
  empaquetador_2a8_if.slave bus_io
);

  localparam int unsigned CntW = $clog2(N_SLOTS);
  localparam logic [CntW-1:0] LastSlot = CntW'(N_SLOTS - 1);

  logic [CntW-1:0]  count_q, count_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  estado_e          state_q, state_d;
  estado_e          estado;

  logic             valid_out;
  logic             last;
  logic             bloqueado;
  logic             ready_out;
  logic             accept;
  logic             load;
  logic             valid_nx;
  logic [OUT_W-1:0] word;

  assign last      = (count_q == LastSlot);
  assign bloqueado = last && valid_out && !bus_io.ready_in;
  assign accept    = bus_io.valid_in && ready_out;
  assign load      = accept && last;
  assign valid_nx  = load || (valid_out && !bus_io.ready_in);
  // last symbol goes straight to the output register, bypassing the accumulator
  assign word      = acc_q | (OUT_W'(bus_io.data_in) << (SYM_W * (N_SLOTS - 1)));

  always_comb begin
    count_d = count_q;
    acc_d   = acc_q;
    if (accept) begin
      if (last) begin
        count_d = '0;
        acc_d   = '0;
      end else begin
        count_d = count_q + CntW'(1);
        acc_d[count_q*SYM_W +: SYM_W] = bus_io.data_in;
      end
    end
  end

  // state_q tracks occupancy; BLOQUEADO depends on this cycle's ready_in, so it is combinational
  always_comb begin
    state_d = state_q;
    if (count_d == '0 && !valid_nx) begin
      state_d = ESPERA;
    end else begin
      state_d = LLENANDO;
    end
    estado    = bloqueado ? BLOQUEADO : state_q;
    ready_out = !reset_L || (estado != BLOQUEADO);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      count_q <= '0;
      acc_q   <= '0;
      state_q <= ESPERA;
    end else begin
      count_q <= count_d;
      acc_q   <= acc_d;
      state_q <= state_d;
    end
  end

  empaq_reg_salida #(
    .OUT_W (OUT_W)
  ) u_reg_salida (
    .clk_i    (clk),
    .reset_ni (reset_L),
    .load_i   (load),
    .word_i   (word),
    .ready_i  (bus_io.ready_in),
`ifdef EMPAQ_PARITY_EN
    .parity_o (bus_io.parity_out),
`endif
    .valid_o  (valid_out),
    .data_o   (bus_io.data_out)
  );

  assign bus_io.valid_out = valid_out;
  assign bus_io.ready_out = ready_out;

endmodule

// File: doc/empaquetador_2a8.md
Name: empaquetador_2a8

Overview:
- Downstream consumer of the registered 2-bit mux output (mux with memory).
- Collects N_SLOTS consecutive 2-bit symbols and packs them into one wide word.
- Presents the word to the next stage through a valid/ready handshake.
- Holds the word under backpressure and stalls upstream only when it cannot buffer further.

Parameters:
- SYM_W, 2: width of one input symbol; must match the mux data_out width.
- N_SLOTS, 4: symbols per packed word; legal range 2..8.
- OUT_W, SYM_W*N_SLOTS: packed word width; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset_L  input  1  synchronous, active-low reset, sampled on posedge clk.
- valid_in  input  1  data_in carries a symbol this cycle.
- data_in  input  SYM_W  symbol from the mux stage.
- ready_out  output  1  block accepts a symbol this cycle.
- valid_out  output  1  data_out holds a complete word.
- data_out  output  OUT_W  packed word.
- ready_in  input  1  downstream accepts the word this cycle.

Behaviour:
- Reset, when reset_L=0 at posedge:
  - valid_out=0, data_out=0, slot count=0, accumulator=0, state=ESPERA.
  - ready_out is combinational and reads 1 during and after reset.
- Reset mid-operation discards any partial word and any held output word. Nothing is flushed.
- Handshakes:
  - Accept = valid_in && ready_out.
  - Transfer out = valid_out && ready_in.
- Packing order:
  - The first accepted symbol lands in data_out[SYM_W-1:0]; slot k lands in bits [k*SYM_W +: SYM_W].
- Slot counter:
  - Width $clog2(N_SLOTS), range 0..N_SLOTS-1.
  - Increments on each accept.
  - Wraps to 0 on the accept of the last slot.
- States:
  - ESPERA: count=0, output register empty.
  - LLENANDO: 0<count<N_SLOTS, or count=0 with output register full.
  - BLOQUEADO: count=N_SLOTS-1, output register full, ready_in=0.
- ready_out = !(count==N_SLOTS-1 && valid_out && !ready_in). It is combinational and equals 0 only in BLOQUEADO.
- Latency: the last-slot accept at edge t gives valid_out=1 and the full word on data_out from t+1. That is one cycle.
- Output register:
  - Loads on the last-slot accept.
  - Clears valid_out on a transfer with no simultaneous load.
  - On a simultaneous transfer and load, the new word replaces the old and valid_out stays 1.
  - data_out is stable while valid_out=1 and ready_in=0.
- valid_in=0 leaves count and accumulator unchanged. There are no bubbles inside a word.
- data_out retains its last value after a transfer. Checkers must only sample it when valid_out=1.
- Throughput: one word per N_SLOTS cycles with ready_in held at 1.

Optional Feature:
- Macro: EMPAQ_PARITY_EN.
- Defined:
  - Adds output port parity_out (1 bit) = XOR reduction of the word.
  - Registered together with data_out; same load and hold rules.
  - Reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package empaq_pkg holds:
  - SYM_W and N_SLOTS default constants.
  - State typedef {ESPERA, LLENANDO, BLOQUEADO}, 2-bit encoding.
- Sub-module empaq_reg_salida: the output holding register with valid/ready, OUT_W parameter and optional parity. The top instantiates it once.

Test Plan:
1. Reset, then valid_in=1 for 4 cycles with symbols 01,10,11,00 and ready_in=1 -> valid_out=1 one cycle after the 4th accept, data_out=8'h39 (8'b00_11_10_01), for exactly 1 cycle.
2. Backpressure: ready_in=0 while feeding 8 symbols (01,10,11,00, then 11,11,11,11) with valid_in=1 ->
   - data_out holds 8'h39.
   - ready_out=0 before the 8th symbol is accepted.
   - Raising ready_in -> 8'h39 transfers, then 8'hFF is accepted and valid_out=1 the next cycle.
3. Gaps: valid_in toggles 1,0,1,0 with symbols 11,xx,01,xx, then 10,00 -> count holds across the gaps; data_out=8'h27 (8'b00_10_01_11).
4. Reset mid-word: accept 2 symbols, reset_L=0 for 1 cycle, then feed 10,10,10,10 -> data_out=8'hAA; no stale bits; valid_out=0 during reset.
5. Simultaneous transfer and load: valid_out=1 with ready_in=1 on the cycle the next word's last symbol is accepted -> the next word appears with no valid_out drop.
6. EMPAQ_PARITY_EN defined:
   - Word 8'h39 -> parity_out=0.
   - Word 8'h38 (symbols 00,10,11,00) -> parity_out=1.
   - Build without the macro compiles with no parity_out port.
